// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } txState_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } txState_t;
`endif

   localparam int STAT_FULL  = 0;
   localparam int STAT_EMPTY = 1;
   localparam int STAT_BUSY  = 2;
   localparam int STAT_OVF   = 3;

   localparam logic [31:0] REG_TXDATA = 32'h0;
   localparam logic [31:0] REG_STATUS = 32'h4;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted only when a
// pop happens on the same edge, otherwise the caller sees it as dropped.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             CLK,
   input  logic             ResetN,
   input  logic             push,
   input  logic [WIDTH-1:0] pushData,
   input  logic             pop,
   output logic [WIDTH-1:0] popData,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wrPtr;
   logic [AW:0]      rdPtr;
   logic             popOk;
   logic             pushOk;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty   = (wrPtr == rdPtr);
   assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
   assign popOk   = pop && !empty;
   assign pushOk  = push && (!full || popOk);
   assign popData = mem[rdPtr[AW-1:0]];

   always_ff @(posedge CLK or negedge ResetN) begin
      if (!ResetN) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (pushOk) wrPtr <= wrPtr + 1'b1;
         if (popOk)  rdPtr <= rdPtr + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (pushOk) mem[wrPtr[AW-1:0]] <= pushData;
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS decode, sticky overflow,
// framing FSM and baud counter. Define UART_TX_PARITY_EN for even parity.
module uart_tx_mmio
   import uart_pkg::*;
#(
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0100
) (
   input  logic        CLK,
   input  logic        ResetN,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   output logic [31:0] ReadData,
   output logic        TxD,
   output logic        TxBusy
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   txState_t   state;
   txState_t   nextState;
   logic [CNT_W-1:0] baudCnt;
   logic [2:0] bitIdx;
   logic [7:0] dataReg;
   logic       ovf;
   logic       pop;
   logic       bitDone;
   logic       txLine;
   logic       fifoFull;
   logic       fifoEmpty;
   logic [7:0] fifoData;
   logic       txDataHit;
   logic       statusAddr;
   logic       unusedWriteData;

   assign txDataHit       = MemWrite && (DataAdr == BASE_ADDR + REG_TXDATA);
   assign statusAddr      = (DataAdr == BASE_ADDR + REG_STATUS);
   assign bitDone         = (baudCnt == CNT_W'(CLKS_PER_BIT - 1));
   assign unusedWriteData = ^WriteData[31:8];

   uart_tx_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) txFifo (
      .CLK      (CLK),
      .ResetN   (ResetN),
      .push     (txDataHit),
      .pushData (WriteData[7:0]),
      .pop      (pop),
      .popData  (fifoData),
      .full     (fifoFull),
      .empty    (fifoEmpty)
   );

   // Overflow is sticky until firmware writes STATUS with bit 3 set.
   always_ff @(posedge CLK or negedge ResetN) begin
      if (!ResetN) begin
         ovf <= 1'b0;
      end else if (txDataHit && fifoFull && !pop) begin
         ovf <= 1'b1;
      end else if (MemWrite && statusAddr && WriteData[STAT_OVF]) begin
         ovf <= 1'b0;
      end
   end

   always_comb begin
      ReadData = '0;
      if (statusAddr) begin
         ReadData[STAT_FULL]  = fifoFull;
         ReadData[STAT_EMPTY] = fifoEmpty;
         ReadData[STAT_BUSY]  = TxBusy;
         ReadData[STAT_OVF]   = ovf;
      end
   end

   always_ff @(posedge CLK or negedge ResetN) begin
      if (!ResetN) begin
         state   <= ST_IDLE;
         baudCnt <= '0;
         bitIdx  <= '0;
         dataReg <= '0;
      end else begin
         state <= nextState;
         if (state == ST_IDLE || bitDone) begin
            baudCnt <= '0;
         end else begin
            baudCnt <= baudCnt + 1'b1;
         end
         if (pop) begin
            bitIdx  <= '0;
            dataReg <= fifoData;
         end else if (state == ST_DATA && bitDone) begin
            bitIdx <= bitIdx + 1'b1;
         end
      end
   end

   // The head byte is popped on the same edge the frame starts, so STOP can
   // chain straight into the next START without an idle gap.
   always_comb begin
      nextState = state;
      pop       = 1'b0;
      txLine    = 1'b1;
      case (state)
         ST_IDLE: begin
            if (!fifoEmpty) begin
               pop       = 1'b1;
               nextState = ST_START;
            end
         end
         ST_START: begin
            txLine = 1'b0;
            if (bitDone) nextState = ST_DATA;
         end
         ST_DATA: begin
            txLine = dataReg[bitIdx];
            if (bitDone && bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
               nextState = ST_PARITY;
`else
               nextState = ST_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            txLine = ^dataReg;
            if (bitDone) nextState = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (bitDone) begin
               if (!fifoEmpty) begin
                  pop       = 1'b1;
                  nextState = ST_START;
               end else begin
                  nextState = ST_IDLE;
               end
            end
         end
         default: nextState = ST_IDLE;
      endcase
   end

   assign TxD    = txLine;
   assign TxBusy = (state != ST_IDLE);

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the processor's data bus, downstream of the core's store port. Consumes `DataAdr`, `WriteData` and `MemWrite` from `top` and returns status on `ReadData`. Buffers bytes in a small FIFO and serialises them on `TxD` as 8N1 frames, LSB first. Lets firmware on the single-cycle core emit text without busy-waiting per bit.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; ≥2.
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, ≥2.
- `BASE_ADDR`, 32'h0000_0100: byte address of TXDATA. STATUS is at `BASE_ADDR+4`.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `ResetN`  in  1  asynchronous, active-low reset.
- `DataAdr`  in  32  core data address.
- `WriteData`  in  32  core store data.
- `MemWrite`  in  1  core store strobe, sampled at rising `CLK`.
- `ReadData`  out  32  combinational read data; 0 unless `DataAdr` hits STATUS.
- `TxD`  out  1  serial output; idle high.
- `TxBusy`  out  1  high while a frame is on the line.

## Operation
- **Decode:** full 32-bit compare. Stores to any other address are ignored.
- **TXDATA write** (`MemWrite` and `DataAdr==BASE_ADDR`):
  - Pushes `WriteData[7:0]`.
  - If the FIFO is full before the edge and no pop occurs on that edge, the byte is dropped and sticky `ovf` sets.
  - If the FIFO is full and a pop occurs on the same edge, the push is accepted and the count is unchanged.
- **STATUS read:** `ReadData` = {28'b0, ovf, busy, empty, full} (bit3..bit0). Reads of TXDATA return 0.
- **STATUS write:** `WriteData[3]==1` clears `ovf`. All other bits are ignored.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty; pops the head into the shift register on the same edge.
  - START holds `TxD`=0 for `CLKS_PER_BIT` cycles, then goes to DATA.
  - DATA shifts bits 0..7, each for `CLKS_PER_BIT` cycles, using a 3-bit index.
  - STOP holds `TxD`=1 for `CLKS_PER_BIT` cycles.
  - At the end of STOP: go to START and pop if the FIFO is non-empty (no idle gap), else go to IDLE.
- **Baud counter:** counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on each bit boundary. Width is `$clog2(CLKS_PER_BIT)`.
- **FIFO pointers:** `$clog2(FIFO_DEPTH)+1` bits; wrap naturally. Full/empty derive from the MSB compare.
- **`TxBusy`:** high in START, DATA and STOP.
- **Reset values:** `TxD`=1, `TxBusy`=0, FSM=IDLE, FIFO empty, `ovf`=0, counters 0.
- **Reset mid-frame:** the line returns high immediately (asynchronous). The frame and all FIFO contents are discarded.

## Timing
- A TXDATA store on edge N with the FSM idle:
  - Byte is in the FIFO after edge N.
  - Popped on edge N+1; `TxD` falls and `TxBusy` rises after edge N+1.
- Frame length is 10×`CLKS_PER_BIT` cycles (11× with parity).
- `TxBusy` falls on the edge that ends STOP, unless a back-to-back frame starts.
- Status bits are registered state; `ReadData` reflects them combinationally within the same cycle.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - Adds a PARITY state between DATA and STOP, lasting `CLKS_PER_BIT` cycles.
  - Even parity: the bit equals the XOR of the 8 data bits.
- `UART_TX_PARITY_EN` undefined: no PARITY state; frames are strictly 8N1.

## Structure
- Package `uart_pkg`:
  - FSM state enum.
  - STATUS bit-position constants.
  - Register offsets TXDATA=0, STATUS=4.
- Sub-module `uart_tx_fifo`:
  - Parameterised by width and depth.
  - push/pop/full/empty ports; same-edge push+pop.
- Top level holds the address decode, `ovf`, FSM, baud counter and shifter.

## Test plan
All scenarios use `CLKS_PER_BIT`=4, `FIFO_DEPTH`=4, `BASE_ADDR`=0x100.
1. **Reset:** `ResetN`=0, then release → `TxD`=1, `TxBusy`=0, read 0x104 gives 0x2.
2. **Single byte:** store 0x55 to 0x100 on edge N →
   - `TxD`=0 for cycles N+1..N+4.
   - Then bits 1,0,1,0,1,0,1,0, 4 cycles each.
   - Then 1 for 4 cycles.
   - `TxBusy` high for exactly 40 cycles.
3. **Overflow:** stores 0x01..0x06 to 0x100 on consecutive edges →
   - 0x06 is dropped; STATUS reads 0xD.
   - Frames 0x01..0x05 are sent back-to-back with `TxBusy` continuously high for 200 cycles.
4. **Clear overflow:** store 0x8 to 0x104 → STATUS bit3=0 from the next cycle. Bits 0–2 are unchanged.
5. **Reset mid-frame:** assert `ResetN` low during data bit 3 →
   - `TxD`=1 immediately.
   - After release, STATUS=0x2 and no further frame is sent.
6. **Parity** (with `UART_TX_PARITY_EN`): store 0x07 → parity bit=1; frame is 44 cycles. Store 0x03 → parity bit=0.
